// File: rtl/fetchqueue_pkg.sv
// ============================================================================
// fetchqueue_pkg : bus widths and default queue depth for the fetch front end
// Revision 1.0
// ============================================================================
`default_nettype none

package fetchqueue_pkg;

  localparam int WORDSIZE     = 32;
  localparam int INSTSIZE     = 32;
  localparam int FETCHQ_DEPTH = 4;

  typedef logic [WORDSIZE-1:0] word_t;
  typedef logic [INSTSIZE-1:0] inst_t;

endpackage

`default_nettype wire

// File: rtl/fetchqueue_ram.sv
// ============================================================================
// fetchqueue_ram : DEPTH x (addr + instruction) storage, independent write
//                  ports for the address and data halves, one async read port
// Revision 1.0
// ============================================================================
`default_nettype none

module fetchqueue_ram
  import fetchqueue_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                i_awe,
  input  logic [PTRW-1:0]     i_aidx,
  input  logic [WORDSIZE-1:0] i_addr,
  input  logic                i_dwe,
  input  logic [PTRW-1:0]     i_didx,
  input  logic [INSTSIZE-1:0] i_data,
  input  logic [PTRW-1:0]     i_ridx,
  output logic [WORDSIZE-1:0] o_addr,
  output logic [INSTSIZE-1:0] o_data
);

  logic [WORDSIZE-1:0] r_addr_mem [DEPTH];
  logic [INSTSIZE-1:0] r_data_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_awe) r_addr_mem[i_aidx] <= i_addr;
    if (i_dwe) r_data_mem[i_didx] <= i_data;
  end

  assign o_addr = r_addr_mem[i_ridx];
  assign o_data = r_data_mem[i_ridx];

endmodule

`default_nettype wire

// File: rtl/fetchqueue.sv
// ============================================================================
// fetchqueue : in-order instruction fetch queue with request/grant issue,
//              stale-response drop on flush. Option: FETCHQ_BYPASS_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module fetchqueue
  import fetchqueue_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORDSIZE-1:0] pc,
  input  logic                flush,
  output logic                stall,
  output logic                mem_req,
  output logic [WORDSIZE-1:0] mem_addr,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [INSTSIZE-1:0] mem_rdata,
  output logic                inst_valid,
  output logic [INSTSIZE-1:0] inst,
  output logic [WORDSIZE-1:0] inst_pc,
  input  logic                inst_ready
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [PTRW-1:0] c_PTR_ONE = PTRW'(1);
  localparam logic [CNTW-1:0] c_CNT_ONE = CNTW'(1);
  localparam logic [CNTW:0]   c_DEPTH   = (CNTW+1)'(DEPTH);

  logic [PTRW-1:0]  r_head, r_rptr, r_fptr;
  logic [CNTW-1:0]  r_count, r_drop;
  logic [DEPTH-1:0] r_filled;

  logic             w_grant, w_pop, w_resp_fill, w_resp_drop, w_bypass;
  logic [CNTW-1:0]  w_nfilled, w_drop_flush;
  logic [DEPTH-1:0] w_filled_nxt;
  logic [WORDSIZE-1:0] w_ram_addr;
  logic [INSTSIZE-1:0] w_ram_data;

  assign mem_req     = rst && !flush && (({1'b0, r_count} + {1'b0, r_drop}) < c_DEPTH);
  assign mem_addr    = pc;
  assign w_grant     = mem_req && mem_gnt;
  assign stall       = !rst || (!w_grant && !flush);
  assign w_resp_drop = mem_rvalid && (r_drop != '0);
  assign w_resp_fill = mem_rvalid && (r_drop == '0);

`ifdef FETCHQ_BYPASS_EN
  // Head is the oldest unfilled entry exactly when the fill pointer sits on it.
  assign w_bypass = w_resp_fill && (r_count != '0) && (r_fptr == r_head) && !r_filled[r_head];
`else
  assign w_bypass = 1'b0;
`endif

  assign inst_valid = r_filled[r_head] || w_bypass;
  assign w_pop      = inst_valid && inst_ready && !flush;
  assign inst       = !inst_valid ? '0 : (w_bypass ? mem_rdata : w_ram_data);
  assign inst_pc    = inst_valid ? w_ram_addr : '0;

  always_comb begin
    w_nfilled = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_nfilled = w_nfilled + {{PTRW{1'b0}}, r_filled[i]};
    end
  end

  // A response landing in the flush cycle is consumed here whether it was
  // already owed to drop or belonged to a (now unfilled) queue entry.
  assign w_drop_flush = r_drop + (r_count - w_nfilled) - {{PTRW{1'b0}}, mem_rvalid};

  always_comb begin
    w_filled_nxt = r_filled;
    if (w_pop) w_filled_nxt[r_head] = 1'b0;
    if (w_resp_fill && !(w_bypass && w_pop)) w_filled_nxt[r_fptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head   <= '0;
      r_rptr   <= '0;
      r_fptr   <= '0;
      r_count  <= '0;
      r_drop   <= '0;
      r_filled <= '0;
    end else if (flush) begin
      r_head   <= '0;
      r_rptr   <= '0;
      r_fptr   <= '0;
      r_count  <= '0;
      r_drop   <= w_drop_flush;
      r_filled <= '0;
    end else begin
      if (w_grant)     r_rptr <= r_rptr + c_PTR_ONE;
      if (w_resp_fill) r_fptr <= r_fptr + c_PTR_ONE;
      if (w_pop)       r_head <= r_head + c_PTR_ONE;
      if (w_resp_drop) r_drop <= r_drop - c_CNT_ONE;
      if (w_grant && !w_pop)      r_count <= r_count + c_CNT_ONE;
      else if (!w_grant && w_pop) r_count <= r_count - c_CNT_ONE;
      r_filled <= w_filled_nxt;
    end
  end

  fetchqueue_ram #(
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_ram (
    .clk    (clk),
    .i_awe  (w_grant),
    .i_aidx (r_rptr),
    .i_addr (pc),
    .i_dwe  (w_resp_fill),
    .i_didx (r_fptr),
    .i_data (mem_rdata),
    .i_ridx (r_head),
    .o_addr (w_ram_addr),
    .o_data (w_ram_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetchqueue.sv
// ============================================================================
// tb_fetchqueue : randomized bench for fetchqueue against a queue-based model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fetchqueue;
  import fetchqueue_pkg::*;

  localparam int DEPTH = FETCHQ_DEPTH;

  logic                clk = 1'b0;
  logic                rst;
  logic [WORDSIZE-1:0] pc;
  logic                flush;
  logic                stall;
  logic                mem_req;
  logic [WORDSIZE-1:0] mem_addr;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [INSTSIZE-1:0] mem_rdata;
  logic                inst_valid;
  logic [INSTSIZE-1:0] inst;
  logic [WORDSIZE-1:0] inst_pc;
  logic                inst_ready;

  always #5 clk = ~clk;

  fetchqueue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .flush      (flush),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  typedef struct {
    logic [WORDSIZE-1:0] addr;
    logic [INSTSIZE-1:0] data;
    bit                  filled;
  } ent_t;

  typedef struct {
    logic [INSTSIZE-1:0] data;
    int                  due;
  } rsp_t;

  ent_t m_q[$];
  rsp_t mem_q[$];
  int   m_drop;
  int   cyc;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   p_gnt, p_rv, p_ready, p_flush, kmax;
  logic [WORDSIZE-1:0] nxt_pc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    bit g, rv, rd, fl, e_req, e_grant, e_stall, e_valid, bypass;
    logic [INSTSIZE-1:0] rdat, e_inst;
    logic [WORDSIZE-1:0] e_pc;
    int unf;
    @(negedge clk);
    pc    = nxt_pc;
    g     = ($urandom_range(99) < p_gnt);
    rv    = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < p_rv);
    rdat  = rv ? mem_q[0].data : $urandom;
    rd    = ($urandom_range(99) < p_ready);
    fl    = ($urandom_range(99) < p_flush);
    mem_gnt = g; mem_rvalid = rv; mem_rdata = rdat; inst_ready = rd; flush = fl;
    #1;
    e_req   = !fl && (m_q.size() + m_drop < DEPTH);
    e_grant = e_req && g;
    e_stall = !e_grant && !fl;
    bypass  = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    bypass  = rv && (m_drop == 0) && (m_q.size() > 0) && !m_q[0].filled;
`endif
    e_valid = ((m_q.size() > 0) && m_q[0].filled) || bypass;
    e_inst  = bypass ? rdat : ((m_q.size() > 0) ? m_q[0].data : '0);
    e_pc    = (m_q.size() > 0) ? m_q[0].addr : '0;
    check_eq("mem_req", 64'(mem_req), 64'(e_req));
    check_eq("stall", 64'(stall), 64'(e_stall));
    check_eq("mem_addr", 64'(mem_addr), 64'(pc));
    check_eq("inst_valid", 64'(inst_valid), 64'(e_valid));
    if (e_valid) begin
      check_eq("inst", 64'(inst), 64'(e_inst));
      check_eq("inst_pc", 64'(inst_pc), 64'(e_pc));
    end
    @(posedge clk);
    if (rv) void'(mem_q.pop_front());
    if (fl) begin
      unf = 0;
      foreach (m_q[i]) if (!m_q[i].filled) unf++;
      m_drop = m_drop + unf - (rv ? 1 : 0);
      m_q.delete();
    end else begin
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < m_q.size(); i++) begin
            if (!m_q[i].filled) begin
              m_q[i].data   = rdat;
              m_q[i].filled = 1'b1;
              break;
            end
          end
        end
      end
      if (e_valid && rd) void'(m_q.pop_front());
      if (e_grant) begin
        m_q.push_back('{pc, '0, 1'b0});
        mem_q.push_back('{$urandom, cyc + 1 + $urandom_range(kmax - 1)});
      end
    end
    if (!e_stall) nxt_pc = fl ? (32'($urandom_range(1023)) << 2) : pc + 32'd4;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd1);
    check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
    check_eq("rst_inst", 64'(inst), 64'd0);
    check_eq("rst_inst_pc", 64'(inst_pc), 64'd0);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; flush = 1'b0; inst_ready = 1'b0;
    m_q.delete(); mem_q.delete(); m_drop = 0;
    nxt_pc = '0; pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run(input int n, input int g, input int r, input int k,
                     input int rd, input int f);
    p_gnt = g; p_rv = r; kmax = k; p_ready = rd; p_flush = f;
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1; pc = '0; nxt_pc = '0; flush = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
    m_drop = 0; cyc = 0;
    do_reset();
    run(20, 100, 100, 1, 100, 0);   // streaming, k=1, decode always ready
    run(10, 100, 100, 1, 0, 0);     // decode blocked: queue fills
    run(1, 100, 100, 1, 100, 0);    // single pop frees one credit
    run(4, 100, 100, 1, 0, 0);
    run(3, 0, 100, 1, 100, 0);      // memory withholds grant
    run(300, 70, 70, 3, 60, 8);
    run(6, 100, 0, 1, 0, 0);        // build up a partly filled queue
    do_reset();
    run(20, 100, 100, 1, 100, 0);
    run(300, 80, 50, 4, 50, 15);
    run(200, 60, 90, 2, 90, 5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
